// File: rtl/cb_cfg_pkg.sv
// Shared definitions for the connection-box configuration loader.
//   cb_state_t   : loader FSM states
//   CB_CHAIN_LEN : number of flops in one CB programming chain
package cb_cfg_pkg;

  localparam int CB_CHAIN_LEN = 69;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } cb_state_t;

endpackage

// File: rtl/cb_cfg_piso.sv
// Parallel-load, indexed-select serializer holding the latched configuration word.
// Ports:
//   prog_clk, rst : clock and asynchronous active-high reset
//   load          : capture load_data into the internal word
//   load_data     : configuration word to capture
//   next_sel      : bit index that will be driven onto the chain next cycle
//   cur_sel       : bit index currently being shifted (used for readback compare)
//   next_bit      : selected bit for next_sel (bypasses the register while loading)
//   cur_bit       : stored bit at cur_sel
module cb_cfg_piso
  import cb_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = CB_CHAIN_LEN,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 prog_clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CHAIN_LEN-1:0] load_data,
  input  logic [CNT_W-1:0]     next_sel,
  input  logic [CNT_W-1:0]     cur_sel,
  output logic                 next_bit,
  output logic                 cur_bit
);

  logic [CHAIN_LEN-1:0] cfg_q_reg;

  always_ff @(posedge prog_clk or posedge rst) begin
    if (rst) begin
      cfg_q_reg <= '0;
    end else if (load) begin
      cfg_q_reg <= load_data;
    end
  end

  // The first serial bit has to be registered in the same edge that latches
  // the word, so while loading it is taken straight from the incoming data.
  assign next_bit = load ? load_data[next_sel] : cfg_q_reg[next_sel];
  assign cur_bit  = cfg_q_reg[cur_sel];

endmodule

// File: rtl/cb_config_loader.sv
// Connection-box scan-chain configuration loader.
// Shifts a latched CHAIN_LEN-bit word LSB first into the CB programming chain,
// optionally shifts it a second time while comparing the bits returned on
// prog_out, and reports the outcome.
// Ports:
//   prog_clk, rst : clock and asynchronous active-high reset
//   start         : load request, honoured only while ready=1
//   verify_en     : captured with start; 1 = run readback pass
//   cfg_data      : configuration word, captured with start
//   ready         : idle, next start will be accepted
//   prog_en       : chain shift enable (registered)
//   prog_in       : serial data into chain (registered)
//   prog_out      : serial data from chain tail
//   done          : one-cycle pulse when a load ends
//   cfg_valid     : last load completed with zero readback mismatches
//   err_count     : mismatches seen in the last readback pass (saturating)
module cb_config_loader
  import cb_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = CB_CHAIN_LEN,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 prog_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 verify_en,
  input  logic [CHAIN_LEN-1:0] cfg_data,
  output logic                 ready,
  output logic                 prog_en,
  output logic                 prog_in,
  input  logic                 prog_out,
  output logic                 done,
  output logic                 cfg_valid,
  output logic [CNT_W-1:0]     err_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] ERR_MAX  = CNT_W'(CHAIN_LEN);

  cb_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] err_reg, err_next;
  logic             verify_reg, verify_next;
  logic             cfg_valid_reg, cfg_valid_next;
  logic             ready_reg, ready_next;
  logic             prog_en_reg, prog_en_next;
  logic             prog_in_reg, prog_in_next;
  logic             done_reg, done_next;
  logic             load;
  logic             next_bit;
  logic             cur_bit;

  cb_cfg_piso #(
    .CHAIN_LEN (CHAIN_LEN),
    .CNT_W     (CNT_W)
  ) u_piso (
    .prog_clk  (prog_clk),
    .rst       (rst),
    .load      (load),
    .load_data (cfg_data),
    .next_sel  (cnt_next),
    .cur_sel   (cnt_reg),
    .next_bit  (next_bit),
    .cur_bit   (cur_bit)
  );

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    err_next       = err_reg;
    verify_next    = verify_reg;
    cfg_valid_next = cfg_valid_reg;
    load           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          load           = 1'b1;
          verify_next    = verify_en;
          err_next       = '0;
          cnt_next       = '0;
          cfg_valid_next = 1'b0;
          state_next     = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (verify_reg) begin
            state_next = VERIFY;
          end else begin
            state_next     = DONE;
            cfg_valid_next = (err_next == '0);
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      VERIFY: begin
        // prog_out in this cycle carries the bit shifted in during the
        // first pass at the same index.
        if ((prog_out != cur_bit) && (err_reg != ERR_MAX)) begin
          err_next = err_reg + 1'b1;
        end
        if (cnt_reg == CNT_LAST) begin
          cnt_next       = '0;
          state_next     = DONE;
          // Includes the compare made in this final verify cycle.
          cfg_valid_next = (err_next == '0);
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so that they come straight
  // out of flops and line up with the state they describe.
  assign prog_en_next = (state_next == SHIFT) || (state_next == VERIFY);
  assign prog_in_next = prog_en_next & next_bit;
  assign ready_next   = (state_next == IDLE);
  assign done_next    = (state_next == DONE);

  always_ff @(posedge prog_clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      err_reg       <= '0;
      verify_reg    <= 1'b0;
      cfg_valid_reg <= 1'b0;
      ready_reg     <= 1'b1;
      prog_en_reg   <= 1'b0;
      prog_in_reg   <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      err_reg       <= err_next;
      verify_reg    <= verify_next;
      cfg_valid_reg <= cfg_valid_next;
      ready_reg     <= ready_next;
      prog_en_reg   <= prog_en_next;
      prog_in_reg   <= prog_in_next;
      done_reg      <= done_next;
    end
  end

  assign ready     = ready_reg;
  assign prog_en   = prog_en_reg;
  assign prog_in   = prog_in_reg;
  assign done      = done_reg;
  assign cfg_valid = cfg_valid_reg;
  assign err_count = err_reg;

endmodule

// File: tb/tb_cb_config_loader.sv
// Testbench for cb_config_loader. A behavioural serial chain is attached as
// the load; expectations come from the load rules (bit order, latency,
// mismatch count from injected readback faults).
module tb_cb_config_loader;

  localparam int N  = 69;
  localparam int CW = $clog2(N + 1);

  logic          prog_clk = 1'b0;
  logic          rst;
  logic          start;
  logic          verify_en;
  logic [N-1:0]  cfg_data;
  logic          ready;
  logic          prog_en;
  logic          prog_in;
  logic          prog_out;
  logic          done;
  logic          cfg_valid;
  logic [CW-1:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural chain: new bits enter at the MSB end, tail is bit 0, so
  // after N shifts the chain holds the word in natural bit order.
  logic [N-1:0] chain = '0;
  int           shift_cnt = 0;
  int           shift_base = 0;
  logic [N-1:0] inj_mask = '0;
  int           vidx;

  always #5 prog_clk = ~prog_clk;

  cb_config_loader #(.CHAIN_LEN(N)) dut (
    .prog_clk  (prog_clk),
    .rst       (rst),
    .start     (start),
    .verify_en (verify_en),
    .cfg_data  (cfg_data),
    .ready     (ready),
    .prog_en   (prog_en),
    .prog_in   (prog_in),
    .prog_out  (prog_out),
    .done      (done),
    .cfg_valid (cfg_valid),
    .err_count (err_count)
  );

  always @(posedge prog_clk) begin
    if (prog_en === 1'b1) begin
      chain     <= {prog_in, chain[N-1:1]};
      shift_cnt <= shift_cnt + 1;
    end
  end

  // vidx = index of the readback bit currently on the tail; inject faults there.
  always_comb begin
    vidx     = shift_cnt - shift_base - N;
    prog_out = chain[0];
    if (vidx >= 0 && vidx < N) begin
      prog_out = chain[0] ^ inj_mask[vidx];
    end
  end

  function automatic logic [N-1:0] rand_word();
    logic [N-1:0] w;
    for (int i = 0; i < N; i++) w[i] = 1'($urandom_range(0, 1));
    return w;
  endfunction

  // One full load, checked against the expected behaviour of the loader.
  task automatic do_load(input logic [N-1:0] w, input bit ver,
                         input logic [N-1:0] mask, input bit hammer,
                         input string name);
    logic [N-1:0]  cap;
    logic [N-1:0]  chain_at;
    logic [CW-1:0] err_at;
    logic          val_at;
    int            en_cnt, done_cnt, done_cyc, exp_lat, exp_err;
    exp_lat = ver ? 2 * N + 1 : N + 1;
    exp_err = 0;
    if (ver) for (int i = 0; i < N; i++) exp_err += int'(mask[i]);
    inj_mask = mask;
    cap = '0; chain_at = '0; err_at = '0; val_at = 1'b0;
    en_cnt = 0; done_cnt = 0; done_cyc = -1;

    @(negedge prog_clk);
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready_before_start got=%b want=1", name, ready);
    end
    cfg_data   = w;
    verify_en  = ver;
    start      = 1'b1;
    shift_base = shift_cnt;

    for (int k = 1; k <= exp_lat + 6; k++) begin
      @(negedge prog_clk);
      if (hammer && k <= 40) begin
        start     = 1'b1;
        cfg_data  = rand_word();
        verify_en = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      if (prog_en === 1'b1) begin
        if (en_cnt < N) cap[en_cnt] = prog_in;
        en_cnt++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = k;
          err_at   = err_count;
          val_at   = cfg_valid;
          chain_at = chain;
        end
      end
    end
    start = 1'b0;

    n_cmp++;
    if (done_cnt != 1) begin
      n_bad++;
      $display("FAIL %s done_pulses got=%0d want=1", name, done_cnt);
    end
    n_cmp++;
    if (done_cyc != exp_lat) begin
      n_bad++;
      $display("FAIL %s done_cycle got=%0d want=%0d", name, done_cyc, exp_lat);
    end
    n_cmp++;
    if (en_cnt != (ver ? 2 * N : N)) begin
      n_bad++;
      $display("FAIL %s prog_en_cycles got=%0d want=%0d", name, en_cnt, ver ? 2 * N : N);
    end
    n_cmp++;
    if (cap !== w) begin
      n_bad++;
      $display("FAIL %s serial_stream got=%h want=%h", name, cap, w);
    end
    n_cmp++;
    if (chain_at !== w) begin
      n_bad++;
      $display("FAIL %s chain_contents got=%h want=%h", name, chain_at, w);
    end
    n_cmp++;
    if (err_at !== CW'(exp_err)) begin
      n_bad++;
      $display("FAIL %s err_count got=%0d want=%0d", name, err_at, exp_err);
    end
    n_cmp++;
    if (val_at !== (exp_err == 0)) begin
      n_bad++;
      $display("FAIL %s cfg_valid_at_done got=%b want=%b", name, val_at, exp_err == 0);
    end
    n_cmp++;
    if (ready !== 1'b1 || cfg_valid !== (exp_err == 0)) begin
      n_bad++;
      $display("FAIL %s idle_after got=ready%b/valid%b want=ready1/valid%b",
               name, ready, cfg_valid, exp_err == 0);
    end
    inj_mask = '0;
    $display("load %s ver=%0d done@%0d err=%0d valid=%0d", name, ver, done_cyc, err_at, val_at);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; verify_en = 1'b0; cfg_data = '0;
    #1;
    repeat (3) @(negedge prog_clk);
    n_cmp++;
    if (ready !== 1'b1 || prog_en !== 1'b0 || prog_in !== 1'b0 || done !== 1'b0 ||
        cfg_valid !== 1'b0 || err_count !== '0) begin
      n_bad++;
      $display("FAIL reset_values got=r%b e%b i%b d%b v%b c%0d want=r1 e0 i0 d0 v0 c0",
               ready, prog_en, prog_in, done, cfg_valid, err_count);
    end
    rst = 1'b0;
    @(negedge prog_clk);
    n_cmp++;
    if (ready !== 1'b1 || prog_en !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_idle got=r%b e%b d%b want=r1 e0 d0", ready, prog_en, done);
    end
  endtask

  task automatic test_basic();
    logic [N-1:0] w;
    w = 69'h1_2345_6789_ABCD_EF01;
    do_load(w, 1'b0, '0, 1'b0, "basic_noverify");
    do_load(w, 1'b1, '0, 1'b0, "basic_verify");
  endtask

  task automatic test_fault();
    logic [N-1:0] m;
    m = '0; m[5] = 1'b1; m[40] = 1'b1;
    do_load(rand_word(), 1'b1, m, 1'b0, "fault_5_40");
    do_load(rand_word(), 1'b1, '1, 1'b0, "fault_all");
  endtask

  task automatic test_random();
    logic [N-1:0] m;
    bit           v;
    for (int t = 0; t < 4; t++) begin
      v = 1'($urandom_range(0, 1));
      m = '0;
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) m[$urandom_range(0, N - 1)] = 1'b1;
      do_load(rand_word(), v, m, 1'b0, "random");
    end
  endtask

  task automatic test_ignore_start();
    do_load(rand_word(), 1'b0, '0, 1'b1, "start_ignored");
  endtask

  task automatic test_mid_reset();
    @(negedge prog_clk);
    cfg_data = rand_word(); verify_en = 1'b0; start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge prog_clk);
      start = 1'b0;
    end
    n_cmp++;
    if (prog_en !== 1'b1 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_shift_active got=e%b r%b want=e1 r0", prog_en, ready);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (prog_en !== 1'b0 || prog_in !== 1'b0 || ready !== 1'b1 ||
        cfg_valid !== 1'b0 || done !== 1'b0 || err_count !== '0) begin
      n_bad++;
      $display("FAIL async_reset got=e%b i%b r%b v%b d%b c%0d want=e0 i0 r1 v0 d0 c0",
               prog_en, prog_in, ready, cfg_valid, done, err_count);
    end
    @(negedge prog_clk);
    rst = 1'b0;
    do_load('1, 1'b1, '0, 1'b0, "after_reset_ones");
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] q[$];
    logic [N-1:0] w;
    int accepted, dones, last_done;
    accepted = 0; dones = 0; last_done = -1;
    inj_mask = '0;
    verify_en = 1'b1;
    for (int c = 0; c < 10 * (2 * N + 2) + 60 && dones < 10; c++) begin
      @(negedge prog_clk);
      if (done === 1'b1) begin
        dones++;
        n_cmp++;
        if (err_count !== '0) begin
          n_bad++;
          $display("FAIL b2b_err_count got=%0d want=0", err_count);
        end
        w = (q.size() > 0) ? q.pop_front() : '0;
        n_cmp++;
        if (chain !== w) begin
          n_bad++;
          $display("FAIL b2b_chain got=%h want=%h", chain, w);
        end
        if (last_done >= 0) begin
          n_cmp++;
          if (c - last_done != 2 * N + 2) begin
            n_bad++;
            $display("FAIL b2b_spacing got=%0d want=%0d", c - last_done, 2 * N + 2);
          end
        end
        last_done = c;
        $display("load b2b #%0d done@%0d err=%0d valid=%0d", dones, c, err_count, cfg_valid);
      end
      if (ready === 1'b1) begin
        if (accepted < 10) begin
          w        = rand_word();
          cfg_data = w;
          start    = 1'b1;
          q.push_back(w);
          accepted++;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (dones != 10) begin
      n_bad++;
      $display("FAIL b2b_done_count got=%0d want=10", dones);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fault();
    test_ignore_start();
    test_mid_reset();
    test_random();
    test_back_to_back();
    repeat (3) @(negedge prog_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
